dual_port_ram_param: RTL and testbench

Parametrised true dual-port synchronous RAM. It is the successor to the fixed 64x8 dual-port RAM, with configurable width and depth, per-port enables, read-valid strobes, and a selectable read-during-write mode. It adds a hardware clear sequencer that initialises every location after reset, plus deterministic write-write collision arbitration with a flag. It sits as the shared buffer between two independent clients in the same clock domain.

---
 rtl/dual_port_ram_param.sv | 190 +++++++++++++++++++
 tb/tb_dual_port_ram_param.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dual_port_ram_param.sv
// Parametrised true dual-port synchronous RAM shared by two clients in one
// clock domain. After reset a clear sequencer writes INIT_VALUE to every
// word; only then are port accesses accepted. Same-address write-write
// collisions keep port A's data and raise a one-cycle collision strobe.

// Per-port read-data output stage. The first register captures the selected
// word on an accepted access; OUT_REG adds one more register stage. The valid
// bits travel alongside as a shift register.
module dual_port_ram_param_port #(
  parameter int DATA_WIDTH = 8,
  parameter int OUT_REG    = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  acc,
  input  logic [DATA_WIDTH-1:0] d,
  output logic [DATA_WIDTH-1:0] q,
  output logic                  valid
);
  localparam int STAGES = (OUT_REG != 0) ? 1 : 0;

  logic [STAGES:0]                 vld_pipe;
  logic [STAGES:0][DATA_WIDTH-1:0] q_pipe;

  // Stage 0 holds its word between accesses; later stages just follow it.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      q_pipe   <= '0;
    end else begin
      vld_pipe[0] <= acc;
      if (acc) q_pipe[0] <= d;
      for (int k = 1; k <= STAGES; k++) begin
        vld_pipe[k] <= vld_pipe[k-1];
        q_pipe[k]   <= q_pipe[k-1];
      end
    end
  end

  assign q     = q_pipe[STAGES];
  assign valid = vld_pipe[STAGES];
endmodule

module dual_port_ram_param #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    ADDR_WIDTH = 6,
  parameter int                    RDW_MODE   = 0,
  parameter int                    OUT_REG    = 0,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  init_done,
  input  logic                  en_a,
  input  logic                  we_a,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [DATA_WIDTH-1:0] data_a,
  output logic [DATA_WIDTH-1:0] q_a,
  output logic                  valid_a,
  input  logic                  en_b,
  input  logic                  we_b,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  input  logic [DATA_WIDTH-1:0] data_b,
  output logic [DATA_WIDTH-1:0] q_b,
  output logic                  valid_b,
  output logic                  collision
);
  localparam int DEPTH     = 2 ** ADDR_WIDTH;
  localparam int NUM_PORTS = 2;

  typedef struct packed {
    logic                  en;
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } req_t;

  typedef enum logic {CLEAR, READY} state_t;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] clr_cnt;
  logic                  clr_last;
  logic                  clr_we;
  logic                  ready;

  req_t [NUM_PORTS-1:0]                  req;
  logic [NUM_PORTS-1:0]                  acc;
  logic [NUM_PORTS-1:0]                  wr;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]  rdata;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]  nxt_q;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]  q_arr;
  logic [NUM_PORTS-1:0]                  vld_arr;
  logic                                  ww_hit;
  logic                                  wr_b_eff;

  assign req[0] = '{en: en_a, we: we_a, addr: addr_a, data: data_a};
  assign req[1] = '{en: en_b, we: we_b, addr: addr_b, data: data_b};

  assign clr_last = (clr_cnt == '1);

  // State register: every reset restarts the clear from address 0.
  always_ff @(posedge clk) begin
    if (rst) state <= CLEAR;
    else     state <= state_nxt;
  end

  // Next state: leave CLEAR once the last address has been written.
  always_comb begin
    state_nxt = state;
    case (state)
      CLEAR:   if (clr_last) state_nxt = READY;
      READY:   state_nxt = READY;
      default: state_nxt = CLEAR;
    endcase
  end

  // FSM outputs: clear-write strobe while clearing, ready afterwards.
  always_comb begin
    clr_we = 1'b0;
    ready  = 1'b0;
    case (state)
      CLEAR:   clr_we = 1'b1;
      READY:   ready  = 1'b1;
      default: clr_we = 1'b1;
    endcase
  end

  assign init_done = ready;

  // Clear address counter; held at zero while reset is asserted.
  always_ff @(posedge clk) begin
    if (rst)         clr_cnt <= '0;
    else if (clr_we) clr_cnt <= clr_cnt + 1'b1;
  end

  // Access qualification. Reset also blocks accesses so nothing lands in
  // memory on the edge that restarts the clear.
  genvar p;
  generate
    for (p = 0; p < NUM_PORTS; p++) begin : g_port
      assign acc[p]   = ready & ~rst & req[p].en;
      assign wr[p]    = acc[p] & req[p].we;
      assign rdata[p] = mem[req[p].addr];
      // Own-port read-during-write: old word, or the data being written.
      assign nxt_q[p] = (wr[p] && (RDW_MODE != 0)) ? req[p].data : rdata[p];

      dual_port_ram_param_port #(
        .DATA_WIDTH (DATA_WIDTH),
        .OUT_REG    (OUT_REG)
      ) u_port (
        .clk   (clk),
        .rst   (rst),
        .acc   (acc[p]),
        .d     (nxt_q[p]),
        .q     (q_arr[p]),
        .valid (vld_arr[p])
      );
    end
  endgenerate

  // Port A wins a same-address double write; B's write is dropped.
  assign ww_hit   = wr[0] & wr[1] & (req[0].addr == req[1].addr);
  assign wr_b_eff = wr[1] & ~ww_hit;

  // Memory array: clear writes while clearing, else the two port writes.
  // Cross-port readers see the pre-edge word because reads sample before
  // these nonblocking updates land.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_cnt] <= INIT_VALUE;
    end else begin
      if (wr[0])    mem[req[0].addr] <= req[0].data;
      if (wr_b_eff) mem[req[1].addr] <= req[1].data;
    end
  end

  // Collision strobe: one cycle after the colliding writes, not delayed
  // by the optional output register.
  always_ff @(posedge clk) begin
    if (rst) collision <= 1'b0;
    else     collision <= ww_hit;
  end

  assign q_a     = q_arr[0];
  assign valid_a = vld_arr[0];
  assign q_b     = q_arr[1];
  assign valid_b = vld_arr[1];
endmodule

// File: tb/tb_dual_port_ram_param.sv
// Directed bench for dual_port_ram_param. Two instances share the stimulus:
// d0 uses defaults (read-first, 1-cycle latency, clear to 0x00) and d1 uses
// write-first, 2-cycle latency, clear to 0xA5. Inputs change 1 time unit
// after a rising edge; outputs are sampled at the same point.
module tb_dual_port_ram_param;
  logic       clk = 1'b0;
  logic       rst;
  logic       en_a, we_a, en_b, we_b;
  logic [5:0] addr_a, addr_b;
  logic [7:0] data_a, data_b;

  logic       id0, va0, vb0, col0;
  logic [7:0] qa0, qb0;
  logic       id1, va1, vb1, col1;
  logic [7:0] qa1, qb1;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dual_port_ram_param d0 (
    .clk(clk), .rst(rst), .init_done(id0),
    .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .data_a(data_a), .q_a(qa0), .valid_a(va0),
    .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .data_b(data_b), .q_b(qb0), .valid_b(vb0),
    .collision(col0)
  );

  dual_port_ram_param #(
    .RDW_MODE(1), .OUT_REG(1), .INIT_VALUE(8'hA5)
  ) d1 (
    .clk(clk), .rst(rst), .init_done(id1),
    .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .data_a(data_a), .q_a(qa1), .valid_a(va1),
    .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .data_b(data_b), .q_b(qb1), .valid_b(vb1),
    .collision(col1)
  );

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%02h expected=0x%02h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkn(input string tag, input int obs, input int exp);
    checks++;
    assert (obs == exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ea, input logic wa, input logic [5:0] aa, input logic [7:0] da,
                       input logic eb, input logic wb, input logic [5:0] ab, input logic [7:0] db);
    en_a = ea; we_a = wa; addr_a = aa; data_a = da;
    en_b = eb; we_b = wb; addr_b = ab; data_b = db;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 6'd0, 8'h00, 1'b0, 1'b0, 6'd0, 8'h00);
  endtask

  // Ticks until d0 reports init_done, bounded; returns the tick count.
  task automatic wait_init(output int n, output logic busy_seen);
    n = 0;
    busy_seen = 1'b0;
    while (!id0 && n < 200) begin
      tick();
      n++;
      if (n == 10) idle();
      busy_seen |= va0 | vb0 | va1 | vb1 | col0 | col1;
    end
  endtask

  int   n, n0, n1;
  logic busy;

  initial begin
    rst = 1'b1;
    idle();
    // Reset held for three cycles.
    repeat (3) tick();
    chk1("rst_init_done0", id0, 1'b0);
    chk1("rst_init_done1", id1, 1'b0);
    chk8("rst_q_a0", qa0, 8'h00);
    chk8("rst_q_b1", qb1, 8'h00);
    chk1("rst_valid_a0", va0, 1'b0);
    chk1("rst_collision0", col0, 1'b0);

    // Release reset with both ports trying to write 0xFF@3 during clear.
    rst = 1'b0;
    drive(1'b1, 1'b1, 6'd3, 8'hFF, 1'b1, 1'b1, 6'd3, 8'hFF);
    wait_init(n, busy);
    chkn("clear_len", n, 64);
    chk1("clear_quiet", busy, 1'b0);
    chk1("clear_init_done1", id1, 1'b1);
    chk8("clear_q_a0_hold", qa0, 8'h00);
    idle();

    // Cleared contents at 0 / 37.
    drive(1'b1, 1'b0, 6'd0, 8'h00, 1'b1, 1'b0, 6'd37, 8'h00);
    tick(); idle();
    chk8("init_rd0_a0", qa0, 8'h00);
    chk8("init_rd37_b0", qb0, 8'h00);
    chk1("init_rd_va0", va0, 1'b1);
    chk1("init_rd_va1_early", va1, 1'b0);
    tick();
    chk8("init_rd0_a1", qa1, 8'hA5);
    chk8("init_rd37_b1", qb1, 8'hA5);
    chk1("init_rd_va0_drop", va0, 1'b0);
    chk1("init_rd_va1", va1, 1'b1);

    // Cleared contents at 63, and @3 untouched by the clear-time requests.
    drive(1'b1, 1'b0, 6'd63, 8'h00, 1'b1, 1'b0, 6'd3, 8'h00);
    tick(); idle();
    chk8("init_rd63_a0", qa0, 8'h00);
    chk8("init_rd3_b0", qb0, 8'h00);
    tick();
    chk8("init_rd63_a1", qa1, 8'hA5);
    chk8("init_rd3_b1", qb1, 8'hA5);

    // Basic writes on both ports.
    drive(1'b1, 1'b1, 6'd5, 8'h3C, 1'b1, 1'b1, 6'd10, 8'hC3);
    tick(); idle();
    chk8("wr_q_a0_old", qa0, 8'h00);
    chk8("wr_q_b0_old", qb0, 8'h00);
    chk1("wr_no_coll0", col0, 1'b0);
    tick();
    chk8("wr_q_a1_new", qa1, 8'h3C);
    chk8("wr_q_b1_new", qb1, 8'hC3);

    // Cross reads.
    drive(1'b1, 1'b0, 6'd10, 8'h00, 1'b1, 1'b0, 6'd5, 8'h00);
    tick(); idle();
    chk8("rd_q_a0", qa0, 8'hC3);
    chk8("rd_q_b0", qb0, 8'h3C);
    chk1("rd_vb0", vb0, 1'b1);
    tick();
    chk8("rd_q_a1", qa1, 8'hC3);
    chk8("rd_q_b1", qb1, 8'h3C);
    chk1("rd_vb1", vb1, 1'b1);
    chk1("rd_vb0_drop", vb0, 1'b0);

    // Read-during-write: mem[7]=0x11, then A writes 0x22@7 while B reads @7.
    drive(1'b1, 1'b1, 6'd7, 8'h11, 1'b0, 1'b0, 6'd0, 8'h00);
    tick(); idle(); tick();
    drive(1'b1, 1'b1, 6'd7, 8'h22, 1'b1, 1'b0, 6'd7, 8'h00);
    tick(); idle();
    chk8("rdw_q_a0_old", qa0, 8'h11);
    chk8("rdw_q_b0_old", qb0, 8'h11);
    tick();
    chk8("rdw_q_a1_new", qa1, 8'h22);
    chk8("rdw_q_b1_old", qb1, 8'h11);
    drive(1'b1, 1'b0, 6'd7, 8'h00, 1'b0, 1'b0, 6'd0, 8'h00);
    tick(); idle();
    chk8("rdw_after_a0", qa0, 8'h22);
    tick();
    chk8("rdw_after_a1", qa1, 8'h22);

    // Write-write collision on @20.
    drive(1'b1, 1'b1, 6'd20, 8'hAA, 1'b1, 1'b1, 6'd20, 8'hBB);
    tick(); idle();
    chk1("coll0_hi", col0, 1'b1);
    chk1("coll1_hi", col1, 1'b1);
    chk8("coll_q_b0_old", qb0, 8'h00);
    tick();
    chk1("coll0_lo", col0, 1'b0);
    chk1("coll1_lo", col1, 1'b0);
    chk8("coll_q_b1_own", qb1, 8'hBB);
    chk1("coll_vb1", vb1, 1'b1);
    drive(1'b1, 1'b0, 6'd20, 8'h00, 1'b0, 1'b0, 6'd0, 8'h00);
    tick(); idle();
    chk8("coll_rd20_a0", qa0, 8'hAA);
    tick();
    chk8("coll_rd20_a1", qa1, 8'hAA);

    // Different addresses: no collision, both words stored.
    drive(1'b1, 1'b1, 6'd20, 8'h01, 1'b1, 1'b1, 6'd21, 8'h02);
    tick(); idle();
    chk1("nocoll0", col0, 1'b0);
    chk1("nocoll1", col1, 1'b0);
    drive(1'b0, 1'b0, 6'd0, 8'h00, 1'b1, 1'b0, 6'd21, 8'h00);
    tick(); idle();
    chk8("nocoll_rd21_b0", qb0, 8'h02);

    // Fill 40..47 with 0x60+i, then alternate en_a on reads of them.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b1, 6'(40 + i), 8'(8'h60 + i), 1'b0, 1'b0, 6'd0, 8'h00);
      tick();
    end
    idle(); tick(); tick();
    for (int i = 0; i < 8; i++) begin
      drive((i % 2) == 0, 1'b0, 6'(40 + i), 8'h00, 1'b0, 1'b0, 6'd0, 8'h00);
      tick();
      chk1("gate_va0", va0, (i % 2) == 0);
      chk8("gate_qa0", qa0, 8'(8'h60 + i - (i % 2)));
      if (i > 0) begin
        chk1("gate_va1", va1, ((i - 1) % 2) == 0);
        chk8("gate_qa1", qa1, 8'(8'h60 + (i - 1) - ((i - 1) % 2)));
      end
    end
    idle(); tick(); tick();

    // Continuous enable for 16 cycles.
    n0 = 0; n1 = 0;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b0, 6'(40 + i), 8'h00, 1'b0, 1'b0, 6'd0, 8'h00);
      tick();
      if (va0) n0++;
      if (va1) n1++;
    end
    idle();
    for (int i = 0; i < 2; i++) begin
      tick();
      if (va0) n0++;
      if (va1) n1++;
    end
    chkn("burst_valid0", n0, 16);
    chkn("burst_valid1", n1, 16);

    // Write 0x55@3 and read @7, then a one-cycle reset mid-operation.
    drive(1'b1, 1'b1, 6'd3, 8'h55, 1'b1, 1'b0, 6'd7, 8'h00);
    tick(); idle();
    chk8("pre_rst_qb0", qb0, 8'h22);
    tick();
    chk8("pre_rst_qa1", qa1, 8'h55);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk8("mid_rst_qb0", qb0, 8'h00);
    chk8("mid_rst_qa1", qa1, 8'h00);
    chk1("mid_rst_init_done0", id0, 1'b0);
    chk1("mid_rst_init_done1", id1, 1'b0);
    wait_init(n, busy);
    chkn("reclear_len", n, 64);
    chk1("reclear_quiet", busy, 1'b0);
    drive(1'b1, 1'b0, 6'd3, 8'h00, 1'b0, 1'b0, 6'd0, 8'h00);
    tick(); idle();
    chk8("reclear_rd3_a0", qa0, 8'h00);
    tick();
    chk8("reclear_rd3_a1", qa1, 8'hA5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
